parallel_chk: RTL and testbench
===============================

PARALLEL_CHK -- requirements
Module: parallel_chk

Interface
REQ-001 Parameter DW, default 32: data word width, legal 8..64.
REQ-002 Parameter BLK_LEN, default 1024: words per pattern block, legal 2..65536.
REQ-003 Parameter ERR_W, default 8: error counter width.
REQ-004 Parameter LOSS_TH, default 8: consecutive mismatches that drop lock in auto mode.
REQ-005 CLK  in  1: single clock; all logic on its rising edge.
REQ-006 RST  in  1: reset, synchronous and active-high.
REQ-007 CLR  in  1: synchronous clear of all state and statistics.
REQ-008 ALIGNED  in  1: upstream word alignment achieved.
REQ-009 DIPUSH  in  1: DIN valid this cycle.
REQ-010 DIN  in  DW: received word.
REQ-011 INIT  in  1: start or restart checking.
REQ-012 MODE  in  1: 0 = fixed start (reference begins at 0); 1 = auto-sync; sampled only with INIT.
REQ-013 LOCKED  out  1: checker in CHECK state.
REQ-014 ERR_PULSE  out  1: one-cycle pulse per mismatched word.
REQ-015 ERR_CNT  out  ERR_W: saturating mismatch count.
REQ-016 WORD_CNT  out  32: saturating count of compared words.
REQ-017 FIRST_ERR  out  DW: DIN of first mismatch since CLR/RST; FIRST_ERR_VLD  out  1: FIRST_ERR holds a capture.

Function
REQ-018 Valid word = ALIGNED & DIPUSH; all other cycles leave pattern state unchanged.
REQ-019 Pattern: each block of BLK_LEN consecutive valid words carries a constant value; the value increments by 1 (mod 2^DW) per block.
REQ-020 States IDLE, HUNT, CHECK; reset/CLR -> IDLE; INIT with MODE=0 -> CHECK, ref=0, pos=0; INIT with MODE=1 -> HUNT.
REQ-021 HUNT: a valid word differing from the previous valid word marks a block boundary -> CHECK, ref=DIN, pos=1; the first valid word in HUNT only primes the previous-word register.
REQ-022 CHECK: each valid word is compared with ref; pos increments; at pos=BLK_LEN-1, pos wraps to 0 and ref increments, all-ones wrapping to 0.
REQ-023 Latency: word sampled at edge k gives ERR_PULSE, ERR_CNT, WORD_CNT and FIRST_ERR updates visible after edge k+1.
REQ-024 ERR_CNT saturates at all-ones; WORD_CNT saturates at 2^32-1; neither wraps.
REQ-025 MODE=1 in CHECK: a run of LOSS_TH consecutive mismatches -> HUNT, LOCKED low; ERR_CNT keeps counting those words; a match resets the run.
REQ-026 MODE=0: lock is never dropped; mismatches only count.
REQ-027 INIT mid-operation restarts per REQ-020 and does not clear ERR_CNT, WORD_CNT or FIRST_ERR; an in-flight pipeline word is discarded.
REQ-028 CLR and INIT in the same cycle: CLR wins, and the state is IDLE.
REQ-029 FIRST_ERR is captured once; later mismatches do not overwrite it until CLR/RST.

Reset
REQ-030 RST or CLR: state IDLE; all outputs 0; ref, pos, mismatch run and pipeline registers 0; RST has priority over CLR.

Structure
REQ-031 Package parallel_chk_pkg holds the state enum and parameter defaults.
REQ-032 One sub-module, sat_counter (width parameter, inc, clr), is instantiated for ERR_CNT and WORD_CNT.

Verification
REQ-033 MODE=0, INIT, 3*BLK_LEN words of correct pattern 0,1,2 -> ERR_CNT=0, WORD_CNT=3*BLK_LEN, LOCKED=1.
REQ-034 MODE=0, word 5 of block 0 = 0xDEADBEEF -> ERR_PULSE one cycle after capture, ERR_CNT=1, FIRST_ERR=0xDEADBEEF.
REQ-035 MODE=1, stream starts mid-block at value 7 -> HUNT until the 7->8 boundary, then CHECK with zero errors.
REQ-036 ERR_W=8, 300 bad words in MODE=0 -> ERR_CNT=255.
REQ-037 MODE=1 locked, LOSS_TH=8 bad words -> LOCKED low, ERR_CNT=8; after the next boundary, relock.
REQ-038 DIPUSH toggled with ALIGNED=0, plus CLR together with INIT -> no counter change; state IDLE.

Source files
------------

// File: rtl/parallel_chk_pkg.sv
// Shared types and parameter defaults for the parallel pattern checker.
//   state_e        : checker FSM encoding (IDLE / HUNT / CHECK)
//   *_DEF          : default values for the parallel_chk parameters
package parallel_chk_pkg;

  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned BLK_LEN_DEF = 1024;
  localparam int unsigned ERR_W_DEF   = 8;
  localparam int unsigned LOSS_TH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset
//   clr  : synchronous clear
//   inc  : increment request; ignored once the count is all-ones
//   cnt  : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/parallel_chk.sv
// Block-incrementing pattern checker. Each block of BLK_LEN valid words holds
// a constant value that increments per block. Fixed-start mode checks from 0;
// auto-sync mode hunts for a block boundary, then checks and drops lock after
// LOSS_TH consecutive mismatches.
//   CLK, RST, CLR         : clock, sync reset, sync clear of all state/stats
//   ALIGNED, DIPUSH, DIN  : received word, valid when ALIGNED & DIPUSH
//   INIT, MODE            : (re)start checking; MODE sampled with INIT
//   LOCKED                : FSM in CHECK
//   ERR_PULSE             : one-cycle pulse per mismatched word
//   ERR_CNT, WORD_CNT     : saturating mismatch / compared-word counts
//   FIRST_ERR(_VLD)       : DIN of first mismatch since CLR/RST
module parallel_chk
  import parallel_chk_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned BLK_LEN = BLK_LEN_DEF,
  parameter int unsigned ERR_W   = ERR_W_DEF,
  parameter int unsigned LOSS_TH = LOSS_TH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             ALIGNED,
  input  logic             DIPUSH,
  input  logic [DW-1:0]    DIN,
  input  logic             INIT,
  input  logic             MODE,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [31:0]      WORD_CNT,
  output logic [DW-1:0]    FIRST_ERR,
  output logic             FIRST_ERR_VLD
);

  localparam int unsigned PW = $clog2(BLK_LEN);
  localparam int unsigned RW = $clog2(LOSS_TH + 1);

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [DW-1:0]   ref_q, ref_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [RW-1:0]   run_q, run_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic            prev_vld_q, prev_vld_d;
  logic            pipe_vld_q, pipe_vld_d;
  logic            pipe_mis_q, pipe_mis_d;
  logic [DW-1:0]   pipe_din_q, pipe_din_d;
  logic            err_pulse_q, err_pulse_d;
  logic [DW-1:0]   first_err_q, first_err_d;
  logic            first_vld_q, first_vld_d;

  logic word_vld, mis, pipe_err, err_inc, word_inc;

  assign word_vld = ALIGNED & DIPUSH;
  assign mis      = (DIN != ref_q);
  assign pipe_err = pipe_vld_q & pipe_mis_q;
  // INIT discards the word sitting in the compare pipeline.
  assign err_inc  = pipe_err & ~INIT;
  assign word_inc = pipe_vld_q & ~INIT;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ref_d       = ref_q;
    pos_d       = pos_q;
    run_d       = run_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    pipe_vld_d  = 1'b0;
    pipe_mis_d  = 1'b0;
    pipe_din_d  = pipe_din_q;
    err_pulse_d = err_inc;
    first_err_d = first_err_q;
    first_vld_d = first_vld_q;

    if (err_inc && !first_vld_q) begin
      first_err_d = pipe_din_q;
      first_vld_d = 1'b1;
    end

    if (INIT) begin
      mode_d     = MODE;
      ref_d      = '0;
      pos_d      = '0;
      run_d      = '0;
      prev_vld_d = 1'b0;
      state_d    = MODE ? ST_HUNT : ST_CHECK;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (word_vld) begin
            if (prev_vld_q && (DIN != prev_q)) begin
              state_d = ST_CHECK;
              ref_d   = DIN;
              pos_d   = PW'(1);
              run_d   = '0;
            end else begin
              prev_d     = DIN;
              prev_vld_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (word_vld) begin
            pipe_vld_d = 1'b1;
            pipe_mis_d = mis;
            pipe_din_d = DIN;
            if (pos_q == PW'(BLK_LEN - 1)) begin
              pos_d = '0;
              ref_d = ref_q + DW'(1);
            end else begin
              pos_d = pos_q + PW'(1);
            end
            if (mode_q) begin
              if (!mis) begin
                run_d = '0;
              end else if (run_q == RW'(LOSS_TH - 1)) begin
                // Lock lost: re-hunt with a fresh previous-word register.
                state_d    = ST_HUNT;
                run_d      = '0;
                prev_vld_d = 1'b0;
              end else begin
                run_d = run_q + RW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      ref_q       <= '0;
      pos_q       <= '0;
      run_q       <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      pipe_vld_q  <= 1'b0;
      pipe_mis_q  <= 1'b0;
      pipe_din_q  <= '0;
      err_pulse_q <= 1'b0;
      first_err_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ref_q       <= ref_d;
      pos_q       <= pos_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_mis_q  <= pipe_mis_d;
      pipe_din_q  <= pipe_din_d;
      err_pulse_q <= err_pulse_d;
      first_err_q <= first_err_d;
      first_vld_q <= first_vld_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (CLR),
    .inc (err_inc),
    .cnt (ERR_CNT)
  );

  sat_counter #(.W(32)) u_word_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (CLR),
    .inc (word_inc),
    .cnt (WORD_CNT)
  );

  assign LOCKED        = (state_q == ST_CHECK);
  assign ERR_PULSE     = err_pulse_q;
  assign FIRST_ERR     = first_err_q;
  assign FIRST_ERR_VLD = first_vld_q;

endmodule

// File: tb/tb_parallel_chk.sv
module tb_parallel_chk;

  localparam int unsigned DW      = 32;
  localparam int unsigned BLK_LEN = 16;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned LOSS_TH = 8;

  logic             CLK = 1'b0;
  logic             RST, CLR, ALIGNED, DIPUSH, INIT, MODE;
  logic [DW-1:0]    DIN;
  logic             LOCKED, ERR_PULSE, FIRST_ERR_VLD;
  logic [ERR_W-1:0] ERR_CNT;
  logic [31:0]      WORD_CNT;
  logic [DW-1:0]    FIRST_ERR;

  parallel_chk #(
    .DW      (DW),
    .BLK_LEN (BLK_LEN),
    .ERR_W   (ERR_W),
    .LOSS_TH (LOSS_TH)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .CLR           (CLR),
    .ALIGNED       (ALIGNED),
    .DIPUSH        (DIPUSH),
    .DIN           (DIN),
    .INIT          (INIT),
    .MODE          (MODE),
    .LOCKED        (LOCKED),
    .ERR_PULSE     (ERR_PULSE),
    .ERR_CNT       (ERR_CNT),
    .WORD_CNT      (WORD_CNT),
    .FIRST_ERR     (FIRST_ERR),
    .FIRST_ERR_VLD (FIRST_ERR_VLD)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int err_model = 0;

  typedef struct {
    int cyc;
    int cnt;
  } rec_t;
  rec_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: each ERR_PULSE must match the oldest expected record.
  always @(negedge CLK) begin
    if (ERR_PULSE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_err_pulse", 64'd1, 64'd0);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        check("err_pulse_cycle", 64'(cyc), 64'(r.cyc));
        check("err_cnt_at_pulse", 64'(ERR_CNT), 64'(r.cnt));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      rec_t r;
      r = exp_q.pop_front();
      check("missing_err_pulse", 64'd0, 64'd1);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ALIGNED = 1'b0; DIPUSH = 1'b0; DIN = '0;
      @(negedge CLK);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit bad);
    rec_t r;
    ALIGNED = 1'b1; DIPUSH = 1'b1; DIN = d;
    @(negedge CLK);
    if (bad) begin
      err_model = (err_model == 255) ? 255 : err_model + 1;
      r.cyc = cyc + 1;
      r.cnt = err_model;
      exp_q.push_back(r);
    end
    ALIGNED = 1'b0; DIPUSH = 1'b0;
  endtask

  task automatic do_init(input logic m);
    INIT = 1'b1; MODE = m;
    @(negedge CLK);
    INIT = 1'b0; MODE = 1'b0;
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    err_model = 0;
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; ALIGNED = 1'b0; DIPUSH = 1'b0;
    DIN = '0; INIT = 1'b0; MODE = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    check("rst_locked", 64'(LOCKED), 64'd0);
    check("rst_err_cnt", 64'(ERR_CNT), 64'd0);
    check("rst_word_cnt", 64'(WORD_CNT), 64'd0);
    check("rst_first_vld", 64'(FIRST_ERR_VLD), 64'd0);
    check("rst_first_err", 64'(FIRST_ERR), 64'd0);
    check("rst_err_pulse", 64'(ERR_PULSE), 64'd0);

    // Fixed start, three clean blocks 0,1,2
    do_init(1'b0);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < int'(BLK_LEN); i++) send(DW'(b), 1'b0);
    idle(2);
    check("clean_err_cnt", 64'(ERR_CNT), 64'd0);
    check("clean_word_cnt", 64'(WORD_CNT), 64'd48);
    check("clean_locked", 64'(LOCKED), 64'd1);

    // Single corrupted word, then a second one that must not overwrite FIRST_ERR
    do_clr();
    do_init(1'b0);
    for (int i = 0; i < int'(BLK_LEN); i++)
      if (i == 5) send(32'hDEADBEEF, 1'b1); else send(32'd0, 1'b0);
    idle(2);
    check("bad5_err_cnt", 64'(ERR_CNT), 64'd1);
    check("bad5_first_err", 64'(FIRST_ERR), 64'hDEADBEEF);
    check("bad5_first_vld", 64'(FIRST_ERR_VLD), 64'd1);
    check("bad5_word_cnt", 64'(WORD_CNT), 64'd16);
    for (int i = 0; i < int'(BLK_LEN); i++)
      if (i == 3) send(32'h12345678, 1'b1); else send(32'd1, 1'b0);
    idle(2);
    check("bad2_err_cnt", 64'(ERR_CNT), 64'd2);
    check("bad2_first_err_kept", 64'(FIRST_ERR), 64'hDEADBEEF);

    // Auto-sync starting mid-block at value 7
    do_clr();
    do_init(1'b1);
    for (int i = 0; i < 5; i++) send(32'd7, 1'b0);
    check("hunt_locked", 64'(LOCKED), 64'd0);
    for (int i = 0; i < int'(BLK_LEN); i++) send(32'd8, 1'b0);
    check("sync_locked", 64'(LOCKED), 64'd1);
    for (int i = 0; i < int'(BLK_LEN); i++) send(32'd9, 1'b0);
    idle(2);
    check("sync_err_cnt", 64'(ERR_CNT), 64'd0);
    check("sync_word_cnt", 64'(WORD_CNT), 64'd31);

    // Loss of lock after LOSS_TH bad words, then relock on next boundary
    for (int i = 0; i < int'(LOSS_TH); i++) send(32'hBAD00000 + 32'(i), 1'b1);
    idle(2);
    check("loss_locked", 64'(LOCKED), 64'd0);
    check("loss_err_cnt", 64'(ERR_CNT), 64'd8);
    for (int i = 0; i < int'(BLK_LEN) - int'(LOSS_TH); i++) send(32'd10, 1'b0);
    check("loss_still_hunt", 64'(LOCKED), 64'd0);
    for (int i = 0; i < int'(BLK_LEN); i++) send(32'd11, 1'b0);
    check("relock_locked", 64'(LOCKED), 64'd1);
    // Interrupted mismatch runs of 7 never reach the threshold
    for (int i = 0; i < int'(BLK_LEN); i++)
      if (i == 7 || i == 15) send(32'd12, 1'b0); else send(32'hCAFE0000 + 32'(i), 1'b1);
    idle(2);
    check("run_reset_locked", 64'(LOCKED), 64'd1);
    check("run_reset_err_cnt", 64'(ERR_CNT), 64'd22);
    check("run_reset_word_cnt", 64'(WORD_CNT), 64'd70);
    do_init(1'b0);
    idle(1);
    check("reinit_err_kept", 64'(ERR_CNT), 64'd22);
    check("reinit_word_kept", 64'(WORD_CNT), 64'd70);
    check("reinit_first_vld", 64'(FIRST_ERR_VLD), 64'd1);
    check("reinit_locked", 64'(LOCKED), 64'd1);

    // Error counter saturation in fixed mode; lock never dropped
    do_clr();
    do_init(1'b0);
    for (int i = 0; i < 300; i++) send(32'hFFFFFFFF, 1'b1);
    idle(2);
    check("sat_err_cnt", 64'(ERR_CNT), 64'd255);
    check("sat_word_cnt", 64'(WORD_CNT), 64'd300);
    check("sat_locked", 64'(LOCKED), 64'd1);

    // Unaligned pushes do nothing; CLR beats INIT
    do_clr();
    do_init(1'b0);
    for (int i = 0; i < 10; i++) begin
      ALIGNED = (i >= 6); DIPUSH = i[0]; DIN = '0;
      if (ALIGNED) DIPUSH = 1'b0;
      @(negedge CLK);
    end
    idle(2);
    check("unaligned_word_cnt", 64'(WORD_CNT), 64'd0);
    CLR = 1'b1; INIT = 1'b1; MODE = 1'b0;
    @(negedge CLK);
    CLR = 1'b0; INIT = 1'b0;
    check("clr_init_locked", 64'(LOCKED), 64'd0);
    send(32'd5, 1'b0);
    idle(2);
    check("idle_word_cnt", 64'(WORD_CNT), 64'd0);
    check("idle_err_cnt", 64'(ERR_CNT), 64'd0);
    check("idle_locked", 64'(LOCKED), 64'd0);

    idle(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
